// File: rtl/vga_dither_pkg.sv
// Shared constants and helpers for the VGA ordered-dither output stage.
package vga_dither_pkg;

  // 4x4 Bayer matrix, row-major: index = {y, x}
  localparam logic [0:15][3:0] BAYER4 = {
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  typedef struct packed {
    logic [2:0][7:0] col;
    logic [7:0]      d;
    logic            win;
    logic            hs;
    logic            vs;
  } stage1_t;

  function automatic logic [3:0] bayer_threshold(input logic [1:0] x, input logic [1:0] y);
    return BAYER4[{y, x}];
  endfunction

  // Add offset, saturate on carry out, keep the top out_bits (right-justified).
  function automatic logic [3:0] dither_quant(input logic [7:0] in8, input logic [7:0] d,
                                              input int out_bits);
    logic [8:0] s;
    s = {1'b0, in8} + {1'b0, d};
    if (s[8]) return 4'((1 << out_bits) - 1);
    return 4'(s[7:0] >> (8 - out_bits));
  endfunction

endpackage

// File: rtl/vga_pos_tracker.sv
// Pixel position within the 4x4 dither cell, derived from sync/window edges.
// VGA_DITHER_TEMPORAL_EN adds a per-frame counter f; otherwise f is 0.
module vga_pos_tracker
  import vga_dither_pkg::*;
#(
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       window_in,
  output logic [1:0] x,
  output logic [1:0] y,
  output logic [1:0] f
);

  logic hs_prev, vs_prev, win_prev;
  logic hs_lead, vs_lead, win_fall;

  assign hs_lead  = (hsync_in == HS_POL) && (hs_prev != HS_POL);
  assign vs_lead  = (vsync_in == VS_POL) && (vs_prev != VS_POL);
  assign win_fall = win_prev && !window_in;

  // History starts inactive so a sync already asserted after reset counts as a leading edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev  <= ~HS_POL;
      vs_prev  <= ~VS_POL;
      win_prev <= 1'b0;
      x        <= 2'd0;
      y        <= 2'd0;
    end else if (pix_ce) begin
      hs_prev  <= hsync_in;
      vs_prev  <= vsync_in;
      win_prev <= window_in;
      if (hs_lead)        x <= 2'd0;
      else if (window_in) x <= x + 2'd1;
      if (vs_lead)        y <= 2'd0;
      else if (win_fall)  y <= y + 2'd1;
    end
  end

`ifdef VGA_DITHER_TEMPORAL_EN
  always_ff @(posedge clk) begin
    if (reset)                 f <= 2'd0;
    else if (pix_ce && vs_lead) f <= f + 2'd1;
  end
`else
  assign f = 2'd0;
`endif

endmodule

// File: rtl/vga_dither_out.sv
// Ordered-dither VGA output stage: 8-bit RGB in, OUT_BITS per channel out, 2-strobe latency.
// With VGA_DITHER_TEMPORAL_EN the Bayer pattern is rotated each frame.
module vga_dither_out
  import vga_dither_pkg::*;
#(
  parameter int OUT_BITS = 3,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_ce,
  input  logic                dither_en,
  input  logic [7:0]          red_in,
  input  logic [7:0]          green_in,
  input  logic [7:0]          blue_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                window_in,
  output logic [OUT_BITS-1:0] red_out,
  output logic [OUT_BITS-1:0] green_out,
  output logic [OUT_BITS-1:0] blue_out,
  output logic                hsync_out,
  output logic                vsync_out
);

  logic [1:0] x, y, f;

  vga_pos_tracker #(
    .HS_POL (HS_POL),
    .VS_POL (VS_POL)
  ) u_pos (
    .clk       (clk),
    .reset     (reset),
    .pix_ce    (pix_ce),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .window_in (window_in),
    .x         (x),
    .y         (y),
    .f         (f)
  );

  // f is 0 without the temporal option, so the lookup collapses to BAYER[y][x].
  logic [1:0] lut_x, lut_y;
  logic [3:0] thr;
  logic [7:0] d;

  assign lut_x = x ^ {f[0], f[1]};
  assign lut_y = y ^ f;
  assign thr   = bayer_threshold(lut_x, lut_y);
  assign d     = dither_en ? (8'(thr) << (4 - OUT_BITS)) : 8'd0;

  stage1_t s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      s1.hs <= ~HS_POL;
      s1.vs <= ~VS_POL;
    end else if (pix_ce) begin
      s1.col <= {red_in, green_in, blue_in};
      s1.d   <= d;
      s1.win <= window_in;
      s1.hs  <= hsync_in;
      s1.vs  <= vsync_in;
    end
  end

  logic [2:0][OUT_BITS-1:0] col_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= '0;
      hsync_out <= ~HS_POL;
      vsync_out <= ~VS_POL;
    end else if (pix_ce) begin
      for (int c = 0; c < 3; c++)
        col_q[c] <= s1.win ? OUT_BITS'(dither_quant(s1.col[c], s1.d, OUT_BITS)) : '0;
      hsync_out <= s1.hs;
      vsync_out <= s1.vs;
    end
  end

  assign red_out   = col_q[2];
  assign green_out = col_q[1];
  assign blue_out  = col_q[0];

endmodule

// File: doc/vga_dither_out.md
Name: vga_dither_out

Overview:
- Output stage between the VirtualToplevel video outputs and the board's low-depth VGA pins.
- Takes 8-bit R/G/B, hsync, vsync and window; produces OUT_BITS-per-channel colour using 4x4 ordered (Bayer) dithering.
- Tracks pixel position from the sync and window signals, and delays syncs to stay aligned with colour.
- Replaces plain MSB truncation, which produces banding.

Parameters:
- OUT_BITS, 3, output bits per channel; legal range 1..4.
- HS_POL, 0, hsync active level (0 = active-low).
- VS_POL, 0, vsync active level (0 = active-low).

Ports:
- clk  in  1  system clock, same as the video source.
- reset  in  1  synchronous, active-high reset.
- pix_ce  in  1  pixel strobe; the pipeline advances only when it is 1; tie high for one pixel per clk.
- dither_en  in  1  1 = ordered dither, 0 = plain truncation.
- red_in, green_in, blue_in  in  8 each  source colour.
- hsync_in, vsync_in  in  1 each  source syncs at HS_POL/VS_POL.
- window_in  in  1  active-video qualifier.
- red_out, green_out, blue_out  out  OUT_BITS each  dithered colour; 0 outside window.
- hsync_out, vsync_out  out  1 each  syncs delayed to match colour.

Behaviour:
- Clock and reset:
  - Single clock domain. reset is synchronous and active-high. Everything below applies on the rising clk edge.
  - Reset values: colour outputs 0; hsync_out = ~HS_POL and vsync_out = ~VS_POL (inactive); x/y counters 0; pipeline valid/window bits 0.
  - Reset mid-frame takes effect on the next edge. Counters restart at 0 and realign at the next hsync/vsync leading edge.
- Hold: when pix_ce = 0, all registers hold, including counters and edge-detect history.
- Edge detection, on pix_ce: keep the previous hsync, vsync and window.
  - hs_lead: hsync changes to HS_POL.
  - vs_lead: vsync changes to VS_POL.
  - win_fall: window goes 1 to 0.
- Position counters, 2 bits each, on pix_ce:
  - x: cleared on hs_lead; otherwise +1 when window_in = 1; wraps 3 to 0.
  - y: cleared on vs_lead; otherwise +1 on win_fall; wraps 3 to 0.
  - Precedence: clear beats increment if both occur on the same cycle.
- Threshold T = BAYER[y][x], 0..15. Rows are 0 8 2 10 / 12 4 14 6 / 3 11 1 9 / 15 7 13 5.
- Dither offset d = T << (4 - OUT_BITS) when OUT_BITS ≤ 4. For OUT_BITS = 3, d = 2T (range 0..30). d = 0 when dither_en = 0.
- Per channel: s = {1'b0, in} + d (9 bits).
  - If s[8] = 1, output saturates to all ones.
  - Otherwise output = s[7:8-OUT_BITS].
- Pipeline, 2 pix_ce-qualified stages:
  - Stage 1 registers colour, d, window, hsync and vsync.
  - Stage 2 registers the add/saturate result with window masking, plus the syncs.
  - Latency is exactly 2 pix_ce strobes for colour and syncs alike.
- Masking: a delayed window of 0 forces colour outputs to 0 regardless of input.
- dither_en is sampled in stage 1. A change mid-line takes effect 2 strobes later with no glitch.

Optional Feature:
- Macro: VGA_DITHER_TEMPORAL_EN.
- Defined:
  - Adds a 2-bit frame counter f, reset to 0, incremented on vs_lead.
  - LUT index becomes BAYER[y ^ {f[1],f[0]}][x ^ {f[0],f[1]}], rotating the pattern every frame.
- Undefined: no frame counter; the pattern is static; the behaviour above is exact.

Decomposition:
- Package vga_dither_pkg:
  - BAYER4 constant (16 × 4-bit).
  - Function bayer_threshold(x, y).
  - Function dither_quant(in8, d, out_bits), which performs saturation and truncation.
- Sub-module vga_pos_tracker: edge detection, x/y counters, and the frame counter when the feature is enabled. It outputs x, y and f.
- Top level: threshold lookup, the 2-stage pipeline and masking.

Test Plan (OUT_BITS = 3, HS_POL = VS_POL = 0, pix_ce = 1 unless stated):
- Assert reset with random inputs → red/green/blue_out = 0 and hsync_out = vsync_out = 1 on the cycle after reset; they stay so until 2 cycles after release.
- dither_en = 0, window = 1, red_in = 0xBF → red_out = 5 exactly 2 cycles later; green_in = 0x20 → 1.
- dither_en = 1, after hs_lead then window rising with y = 0, constant red_in = 0x30 → red_out sequence 1, 2, 1, 2, repeating (T = 0, 8, 2, 10 gives 48/64/52/68 before quantisation).
- dither_en = 1, red_in = 0xFF at x = 0, y = 3 (T = 15, s = 285) → red_out = 7 (saturated, no wrap to 0).
- window low between lines, with hsync pulse and then a vsync pulse → colour 0 during blank; x resets on each hsync; y = 1, 2, 3, 0 over four lines; y = 0 after vsync.
- pix_ce toggling 1, 0, 0, 1 → outputs and counters unchanged on pix_ce = 0 cycles; latency measured as 2 strobes, not 2 clocks.
